dsp_tiled_mac: RTL and testbench

Parametrised, iterative multiply / multiply-accumulate engine. A single (T+1)×(T+1) signed tile multiplier is time-multiplexed over all T-bit tile pairs of the N-bit and M-bit operands, and each partial product is shifted and summed into a wide accumulator. Four modes are supported: multiply, MAC, scaled MAC and MSUB, with optional saturation and a sticky overflow flag. The block generalises the fixed 16×16, four-cycle DSP datapath to arbitrary operand and tile widths, and adds a valid/ready handshake on both sides.

---
 rtl/dsp_tiled_mac_if.sv | 34 +++
 rtl/dsp_tiled_mac.sv | 224 ++++++++++++++++++++++
 tb/tb_dsp_tiled_mac.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_tiled_mac_if.sv
// dsp_tiled_mac_if: command/result bundle of the tiled multiply-accumulate engine.
//   in_valid/in_ready   : command handshake (a, b, mode, shift, sat_en, clr)
//   out_valid/out_ready : result handshake (out, ovf)
//   busy                : engine is not idle
// master drives commands and accepts results; slave is the engine.
interface dsp_tiled_mac_if #(
  parameter int N     = 16,
  parameter int M     = 16,
  parameter int ACC_W = N + M + 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [M-1:0]     b;
  logic [1:0]       mode;
  logic [1:0]       shift;
  logic             sat_en;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, mode, shift, sat_en, clr, out_ready,
    input  in_ready, out_valid, out, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, mode, shift, sat_en, clr, out_ready,
    output in_ready, out_valid, out, ovf, busy
  );
endinterface

// File: rtl/dsp_tiled_mac.sv
// dsp_tiled_mac: iterative multiply / MAC engine built around one
// (T+1)x(T+1) signed tile multiplier that walks every T-bit tile pair of a
// and b (i outer, j inner), then combines the product into a wide
// accumulator (MUL, MAC, scaled MAC, MSUB) with optional saturation and a
// sticky overflow flag.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : dsp_tiled_mac_if slave (command in, result out, busy)
module dsp_tiled_mac #(
  parameter int N      = 16,
  parameter int M      = 16,
  parameter int T      = 8,
  parameter int ACC_W  = N + M + 8,
  parameter int SIGNED = 1
) (
  input  logic           clk,
  input  logic           reset,
  dsp_tiled_mac_if.slave bus
);

  localparam int NT = N / T;
  localparam int MT = M / T;
  localparam int PW = N + M;
  localparam int IW = (NT > 1) ? $clog2(NT) : 1;
  localparam int JW = (MT > 1) ? $clog2(MT) : 1;
  localparam logic [IW-1:0] I_ONE = IW'(1'b1);
  localparam logic [JW-1:0] J_ONE = JW'(1'b1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_r, state_next_s;
  logic [N-1:0]     a_r;
  logic [M-1:0]     b_r;
  logic [1:0]       mode_r, shift_r;
  logic             sat_r;
  logic [IW-1:0]    i_r;
  logic [JW-1:0]    j_r;
  logic [PW-1:0]    prod_r;
  logic [ACC_W-1:0] acc_r;
  logic             ovf_r;
  logic             in_ready_r, out_valid_r, busy_r;

  logic             accept_s, last_tile_s;
  logic [T-1:0]     a_tiles_s [NT];
  logic [T-1:0]     b_tiles_s [MT];
  logic [T-1:0]     tile_a_s, tile_b_s;
  logic [T:0]       ext_a_s, ext_b_s;
  logic signed [2*T+1:0] pp_s;
  logic [PW-1:0]    pp_sh_s;
  logic [ACC_W-1:0] p_s;
  logic [ACC_W:0]   acc_x_s, p_x_s, acc_shr_s, sum_s;
  logic             sum_ovf_s;
  logic [ACC_W-1:0] acc_new_s;

  // Static slicing of the operand registers into T-bit tiles.
  for (genvar g = 0; g < NT; g++) begin : g_a_tiles
    assign a_tiles_s[g] = a_r[g*T +: T];
  end
  for (genvar g = 0; g < MT; g++) begin : g_b_tiles
    assign b_tiles_s[g] = b_r[g*T +: T];
  end

  // Tile multiply: only the most significant tile carries the sign, so it
  // alone is sign-extended; every lower tile is a plain magnitude.
  always_comb begin
    tile_a_s = a_tiles_s[i_r];
    tile_b_s = b_tiles_s[j_r];
    if ((SIGNED != 0) && (int'(i_r) == NT - 1)) begin
      ext_a_s = {tile_a_s[T-1], tile_a_s};
    end else begin
      ext_a_s = {1'b0, tile_a_s};
    end
    if ((SIGNED != 0) && (int'(j_r) == MT - 1)) begin
      ext_b_s = {tile_b_s[T-1], tile_b_s};
    end else begin
      ext_b_s = {1'b0, tile_b_s};
    end
    pp_s        = $signed(ext_a_s) * $signed(ext_b_s);
    // Modulo-2^PW summation is exact because the final product fits PW bits.
    pp_sh_s     = PW'(pp_s) << (T * (int'(i_r) + int'(j_r)));
    last_tile_s = (int'(i_r) == NT - 1) && (int'(j_r) == MT - 1);
  end

  // Final combine: one extra guard bit exposes overflow of the signed range.
  always_comb begin
    if (SIGNED != 0) begin
      p_s = ACC_W'($signed(prod_r));
    end else begin
      p_s = ACC_W'(prod_r);
    end
    acc_x_s   = {acc_r[ACC_W-1], acc_r};
    p_x_s     = {p_s[ACC_W-1], p_s};
    acc_shr_s = $signed(acc_x_s) >>> shift_r;
    case (mode_r)
      2'd0:    sum_s = p_x_s;
      2'd1:    sum_s = acc_x_s + p_x_s;
      2'd2:    sum_s = acc_shr_s + p_x_s;
      2'd3:    sum_s = acc_x_s - p_x_s;
      default: sum_s = p_x_s;
    endcase
    sum_ovf_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
    if (sum_ovf_s && sat_r) begin
      if (sum_s[ACC_W]) begin
        acc_new_s = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        acc_new_s = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      acc_new_s = sum_s[ACC_W-1:0];
    end
  end

  // Next-state logic of the command sequencer.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.in_valid) begin
          accept_s     = 1'b1;
          state_next_s = S_RUN;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_tile_s) begin
          state_next_s = S_ACC;
        end else begin
          state_next_s = S_RUN;
        end
      end
      S_ACC: state_next_s = S_DONE;
      S_DONE: begin
        if (bus.out_ready) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_DONE;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // State register and registered handshake/status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == S_IDLE);
      out_valid_r <= (state_next_s == S_DONE);
      busy_r      <= (state_next_s != S_IDLE);
    end
  end

  // Datapath: command capture, tile iteration and accumulator update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r     <= {N{1'b0}};
      b_r     <= {M{1'b0}};
      mode_r  <= 2'd0;
      shift_r <= 2'd0;
      sat_r   <= 1'b0;
      i_r     <= {IW{1'b0}};
      j_r     <= {JW{1'b0}};
      prod_r  <= {PW{1'b0}};
      acc_r   <= {ACC_W{1'b0}};
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          // A same-cycle clear lands before the accepted command combines.
          if (bus.clr) begin
            acc_r <= {ACC_W{1'b0}};
            ovf_r <= 1'b0;
          end
          if (accept_s) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            mode_r  <= bus.mode;
            shift_r <= bus.shift;
            sat_r   <= bus.sat_en;
            i_r     <= {IW{1'b0}};
            j_r     <= {JW{1'b0}};
            prod_r  <= {PW{1'b0}};
          end
        end
        S_RUN: begin
          prod_r <= prod_r + pp_sh_s;
          if (int'(j_r) == MT - 1) begin
            j_r <= {JW{1'b0}};
            i_r <= i_r + I_ONE;
          end else begin
            j_r <= j_r + J_ONE;
          end
        end
        S_ACC: begin
          acc_r <= acc_new_s;
          ovf_r <= ovf_r | sum_ovf_s;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.out       = acc_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_dsp_tiled_mac.sv
// tb_dsp_tiled_mac: self-checking bench for dsp_tiled_mac. Three instances
// (signed 16x16/ACC 40, signed 16x16/ACC 32, unsigned 32x16/ACC 56) share
// one stimulus bus; sel picks which instance sees in_valid/clr and which
// outputs are observed. Expected results come from a plain-arithmetic model.
module tb_dsp_tiled_mac;

  logic        clk;
  logic        rst_n;
  int          sel;
  logic [31:0] a_d;
  logic [15:0] b_d;
  logic [1:0]  mode_d, shift_d;
  logic        sat_d, clr_d, in_valid_d, out_ready_d;
  logic [63:0] out_m;
  logic        ovf_m, out_valid_m, in_ready_m, busy_m;

  int     n_cmp;
  int     n_err;
  longint macc [3];
  bit     movf [3];
  int     accw [3] = '{40, 32, 56};
  int     nw   [3] = '{16, 16, 32};
  int     sg   [3] = '{1, 1, 0};

  dsp_tiled_mac_if #(.N(16), .M(16), .ACC_W(40)) if0 ();
  dsp_tiled_mac_if #(.N(16), .M(16), .ACC_W(32)) if1 ();
  dsp_tiled_mac_if #(.N(32), .M(16), .ACC_W(56)) if2 ();

  dsp_tiled_mac #(.N(16), .M(16), .T(8), .ACC_W(40), .SIGNED(1)) dut0 (.clk(clk), .reset(rst_n), .bus(if0));
  dsp_tiled_mac #(.N(16), .M(16), .T(8), .ACC_W(32), .SIGNED(1)) dut1 (.clk(clk), .reset(rst_n), .bus(if1));
  dsp_tiled_mac #(.N(32), .M(16), .T(8), .ACC_W(56), .SIGNED(0)) dut2 (.clk(clk), .reset(rst_n), .bus(if2));

  assign if0.in_valid = in_valid_d && (sel == 0);
  assign if1.in_valid = in_valid_d && (sel == 1);
  assign if2.in_valid = in_valid_d && (sel == 2);
  assign if0.clr = clr_d && (sel == 0);
  assign if1.clr = clr_d && (sel == 1);
  assign if2.clr = clr_d && (sel == 2);
  assign if0.a = a_d[15:0];
  assign if1.a = a_d[15:0];
  assign if2.a = a_d;
  assign if0.b = b_d;
  assign if1.b = b_d;
  assign if2.b = b_d;
  assign if0.mode = mode_d;
  assign if1.mode = mode_d;
  assign if2.mode = mode_d;
  assign if0.shift = shift_d;
  assign if1.shift = shift_d;
  assign if2.shift = shift_d;
  assign if0.sat_en = sat_d;
  assign if1.sat_en = sat_d;
  assign if2.sat_en = sat_d;
  assign if0.out_ready = out_ready_d;
  assign if1.out_ready = out_ready_d;
  assign if2.out_ready = out_ready_d;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    case (sel)
      0: begin
        out_m = {24'd0, if0.out}; ovf_m = if0.ovf; out_valid_m = if0.out_valid;
        in_ready_m = if0.in_ready; busy_m = if0.busy;
      end
      1: begin
        out_m = {32'd0, if1.out}; ovf_m = if1.ovf; out_valid_m = if1.out_valid;
        in_ready_m = if1.in_ready; busy_m = if1.busy;
      end
      default: begin
        out_m = {8'd0, if2.out}; ovf_m = if2.ovf; out_valid_m = if2.out_valid;
        in_ready_m = if2.in_ready; busy_m = if2.busy;
      end
    endcase
  end

  function automatic longint mask_w(int w);
    return (64'sd1 <<< w) - 64'sd1;
  endfunction

  function automatic longint sext(longint v, int w);
    longint t;
    t = v <<< (64 - w);
    return t >>> (64 - w);
  endfunction

  // Reference: true product of the operands, then the mode rule on a signed acc.
  function automatic void model_step(int inst, logic [31:0] a, logic [15:0] b,
                                     logic [1:0] mode, logic [1:0] shift, logic sat, logic clr);
    longint pa, pb, p, sum, mx, mn;
    if (clr) begin
      macc[inst] = 0;
      movf[inst] = 1'b0;
    end
    if (sg[inst] != 0) begin
      pa = sext(longint'(a), nw[inst]);
      pb = sext(longint'(b), 16);
    end else begin
      pa = longint'(a) & mask_w(nw[inst]);
      pb = longint'(b);
    end
    p = pa * pb;
    case (mode)
      2'd0:    sum = p;
      2'd1:    sum = macc[inst] + p;
      2'd2:    sum = (macc[inst] >>> shift) + p;
      default: sum = macc[inst] - p;
    endcase
    mx = mask_w(accw[inst] - 1);
    mn = -mx - 64'sd1;
    if (sum > mx || sum < mn) begin
      movf[inst] = 1'b1;
      if (sat) macc[inst] = (sum > mx) ? mx : mn;
      else     macc[inst] = sext(sum, accw[inst]);
    end else begin
      macc[inst] = sum;
    end
  endfunction

  // Issue one command with out_ready held high; check latency, result and handshake.
  task automatic do_cmd(input int inst, input logic [31:0] a, input logic [15:0] b,
                        input logic [1:0] mode, input logic [1:0] shift, input logic sat,
                        input logic clr, input string name,
                        output logic [63:0] got, output logic got_ovf);
    logic [63:0] exp;
    int lat;
    int p_cyc;
    p_cyc = (nw[inst] / 8) * 2;
    sel = inst;
    model_step(inst, a, b, mode, shift, sat, clr);
    exp = 64'(macc[inst] & mask_w(accw[inst]));
    a_d = a; b_d = b; mode_d = mode; shift_d = shift; sat_d = sat; clr_d = clr;
    in_valid_d = 1'b1; out_ready_d = 1'b1;
    #1;
    n_cmp++;
    if (in_ready_m !== 1'b1) begin
      n_err++;
      $display("FAIL %s in_ready_before_accept: got %b want 1", name, in_ready_m);
    end
    @(posedge clk); #1;
    in_valid_d = 1'b0; clr_d = 1'b0;
    lat = 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid_m === 1'b1 || lat >= 40) break;
    end
    got = out_m;
    got_ovf = ovf_m;
    n_cmp++;
    if (out_valid_m !== 1'b1) begin
      n_err++;
      $display("FAIL %s out_valid_timeout: got %b want 1 within 40 cycles", name, out_valid_m);
      return;
    end
    n_cmp++;
    if (lat != p_cyc + 1) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, p_cyc + 1);
    end
    n_cmp++;
    if (out_m !== exp) begin
      n_err++;
      $display("FAIL %s out: got %h want %h", name, out_m, exp);
    end
    n_cmp++;
    if (ovf_m !== movf[inst]) begin
      n_err++;
      $display("FAIL %s ovf: got %b want %b", name, ovf_m, movf[inst]);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1) begin
      n_err++;
      $display("FAIL %s post_handshake: got valid=%b ready=%b want valid=0 ready=1",
               name, out_valid_m, in_ready_m);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid_d = 1'b0; clr_d = 1'b0; out_ready_d = 1'b1;
    a_d = 32'd0; b_d = 16'd0; mode_d = 2'd0; shift_d = 2'd0; sat_d = 1'b0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      n_cmp++;
      if ({in_ready_m, out_valid_m, busy_m, ovf_m} !== 4'b1000) begin
        n_err++;
        $display("FAIL reset_flags inst%0d: got rdy/val/busy/ovf=%b want 1000", k,
                 {in_ready_m, out_valid_m, busy_m, ovf_m});
      end
      n_cmp++;
      if (out_m !== 64'd0) begin
        n_err++;
        $display("FAIL reset_out inst%0d: got %h want 0", k, out_m);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      macc[k] = 0;
      movf[k] = 1'b0;
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic test_directed;
    logic [63:0] g;
    logic o;
    do_cmd(0, 32'h0000FFFD, 16'h0007, 2'd0, 2'd0, 1'b0, 1'b1, "mul_signed", g, o);
    check_val("mul_signed_const", g, 64'h000000FFFFFFFFEB);
    do_cmd(0, 32'd10, 16'd10, 2'd0, 2'd0, 1'b0, 1'b1, "mac_seed", g, o);
    check_val("mac_seed_const", g, 64'd100);
    do_cmd(0, 32'h00007FFF, 16'h7FFF, 2'd1, 2'd0, 1'b0, 1'b0, "mac", g, o);
    check_val("mac_const", g, 64'h0000003FFF0065);
    do_cmd(0, 32'h0000FFF8, 16'h0008, 2'd0, 2'd0, 1'b0, 1'b1, "seed_m64", g, o);
    check_val("seed_m64_const", g, 64'h000000FFFFFFFFC0);
    do_cmd(0, 32'd1, 16'd1, 2'd2, 2'd2, 1'b0, 1'b0, "scaled_mac", g, o);
    check_val("scaled_mac_const", g, 64'h000000FFFFFFFFF1);
    do_cmd(0, 32'd2, 16'd3, 2'd3, 2'd0, 1'b0, 1'b0, "msub", g, o);
    check_val("msub_const", g, 64'h000000FFFFFFFFEB);
  endtask

  task automatic test_saturation;
    logic [63:0] g;
    logic o;
    do_cmd(1, 32'h00008000, 16'h8000, 2'd1, 2'd0, 1'b1, 1'b1, "sat1", g, o);
    check_val("sat1_const", {g[62:0], o}, {63'h40000000, 1'b0});
    do_cmd(1, 32'h00008000, 16'h8000, 2'd1, 2'd0, 1'b1, 1'b0, "sat2", g, o);
    check_val("sat2_const", {g[62:0], o}, {63'h7FFFFFFF, 1'b1});
    do_cmd(1, 32'h00008000, 16'h8000, 2'd1, 2'd0, 1'b0, 1'b1, "wrap1", g, o);
    check_val("wrap1_const", {g[62:0], o}, {63'h40000000, 1'b0});
    do_cmd(1, 32'h00008000, 16'h8000, 2'd1, 2'd0, 1'b0, 1'b0, "wrap2", g, o);
    check_val("wrap2_const", {g[62:0], o}, {63'h80000000, 1'b1});
  endtask

  task automatic test_unsigned;
    logic [63:0] g;
    logic o;
    do_cmd(2, 32'h0000FFFF, 16'hFFFF, 2'd0, 2'd0, 1'b0, 1'b1, "unsigned_ffff", g, o);
    check_val("unsigned_ffff_const", g, 64'h00000000FFFE0001);
    do_cmd(2, 32'h12345678, 16'h9ABC, 2'd0, 2'd0, 1'b0, 1'b0, "unsigned_wide", g, o);
    check_val("unsigned_wide_const", g, 64'h00000B00DA73B020);
  endtask

  task automatic test_backpressure;
    logic [63:0] exp, g;
    logic o;
    logic [31:0] a;
    logic [15:0] b;
    int lat;
    a = $urandom; b = 16'($urandom);
    sel = 0;
    model_step(0, a, b, 2'd1, 2'd0, 1'b0, 1'b0);
    exp = 64'(macc[0] & mask_w(40));
    a_d = a; b_d = b; mode_d = 2'd1; shift_d = 2'd0; sat_d = 1'b0; clr_d = 1'b0;
    out_ready_d = 1'b0; in_valid_d = 1'b1;
    @(posedge clk); #1;
    in_valid_d = 1'b0;
    lat = 0;
    while (out_valid_m !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("bp_result", out_m, exp);
    // Foreign command plus clr while the result waits: both must be ignored.
    in_valid_d = 1'b1; clr_d = 1'b1; a_d = $urandom; mode_d = 2'd0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_val("bp_hold_flags", {62'd0, out_valid_m, in_ready_m}, 64'd2);
      check_val("bp_hold_out", out_m, exp);
    end
    in_valid_d = 1'b0; clr_d = 1'b0; out_ready_d = 1'b1;
    @(posedge clk); #1;
    check_val("bp_release_flags", {62'd0, out_valid_m, in_ready_m}, 64'd1);
    check_val("bp_release_out", out_m, exp);
    do_cmd(0, $urandom, 16'($urandom), 2'd1, 2'd0, 1'b0, 1'b0, "after_bp", g, o);
  endtask

  task automatic test_reset_abort;
    logic [63:0] g;
    logic o;
    sel = 0;
    a_d = 32'h00007FFF; b_d = 16'h7FFF; mode_d = 2'd1; clr_d = 1'b0;
    out_ready_d = 1'b1; in_valid_d = 1'b1;
    @(posedge clk); #1;
    in_valid_d = 1'b0;
    @(posedge clk); #1;
    check_val("abort_busy_before", {63'd0, busy_m}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("abort_flags", {60'd0, in_ready_m, out_valid_m, busy_m, ovf_m}, 64'h8);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      check_val("abort_out", out_m, 64'd0);
      check_val("abort_ovf", {63'd0, ovf_m}, 64'd0);
    end
    sel = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      macc[k] = 0;
      movf[k] = 1'b0;
    end
    do_cmd(0, 32'd3, 16'd5, 2'd1, 2'd0, 1'b0, 1'b0, "after_abort", g, o);
    check_val("after_abort_const", g, 64'd15);
  endtask

  task automatic test_random;
    logic [63:0] g;
    logic o;
    int inst;
    for (int n = 0; n < 60; n++) begin
      inst = $urandom_range(0, 2);
      do_cmd(inst, $urandom, 16'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), "random", g, o);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish before 400000");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_saturation();
    test_unsigned();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
